noc_pkt_checker: RTL and testbench
==================================

// Module: noc_pkt_checker
// PURPOSE
//  Self-checking packet sink at one NoC ejection (local) port; the receive end of the traffic-generator PE.
//  Accepts packets on a valid/ready interface and checks each one: destination coordinate, per-source sequence, latency.
//  Exposes packet/error/latency statistics to the testbench top; one instance per mesh node.
// PARAMETERS
//  XCORD        0    this node's x coordinate
//  YCORD        0    this node's y coordinate
//  X            4    mesh columns
//  Y            4    mesh rows
//  DATA_WIDTH   256  payload width; must be >= SRC_W+SEQ_W+TS_W
//  SEQ_W        16   sequence-number field width
//  TS_W         32   injection-timestamp field width
//  EXP_PKTS     100  packets expected before o_done
//  (derived) X_SIZE=$clog2(X), Y_SIZE=$clog2(Y), SRC_W=$clog2(X*Y), TOTAL_W=X_SIZE+Y_SIZE+DATA_WIDTH
// PORTS
//  clk          in   1        clock
//  rst          in   1        async active-high reset
//  i_data       in   TOTAL_W  packet: [X_SIZE-1:0] dest x, next Y_SIZE dest y, then payload {.., ts, seq, src}
//  i_valid      in   1        packet valid
//  o_ready      out  1        sink ready (registered)
//  o_pkt_cnt    out  32       packets accepted, saturating
//  o_err_cnt    out  32       packets with any error, saturating
//  o_err_code   out  3        sticky OR: [0] wrong dest, [1] seq gap/repeat, [2] src out of range
//  o_lat_min    out  TS_W     minimum latency seen
//  o_lat_max    out  TS_W     maximum latency seen
//  o_done       out  1        o_pkt_cnt >= EXP_PKTS
// BEHAVIOUR
//  Reset: o_ready=0, counters=0, o_err_code=0, o_lat_min=all-ones, o_lat_max=0, o_done=0, seq table=0, cycle ctr=0.
//  o_ready goes to 1 on the first clk edge after reset release; thereafter it follows the stall logic.
//  Accept = i_valid & o_ready. i_data is sampled only on accept; i_data is don't-care otherwise.
//  The upstream must hold i_data stable while valid and not ready.
//  Free-running cycle counter cyc (TS_W bits) wraps modulo 2^TS_W.
//  Pipeline stage S1 (accept edge): register pkt, plus lat = cyc - ts, computed mod 2^TS_W (wrap-safe).
//  Pipeline stage S2 (next edge): check pkt; update expected-seq table exp[src]; update stats. Stats are visible 2 cycles after accept.
//  Dest check: dest x != XCORD or dest y != YCORD -> err bit0.
//  Src check: src >= X*Y -> err bit2. A bad src packet gets no table access and no seq check.
//  Seq check: seq != exp[src] -> err bit1. In both cases exp[src] <= seq+1 (mod 2^SEQ_W) to resync after a gap.
//  Seq wrap: 2^SEQ_W-1 followed by 0 is legal.
//  Hazard: back-to-back accepts from the same src must see the S2-updated exp. Use a bypass; no bubble is allowed.
//  Error packet: o_err_cnt += 1 per packet with any error bit, not once per bit.
//  Latency: min/max update on every in-range packet, including errored ones.
//  Saturation: counters hold at 32'hFFFF_FFFF.
//  o_done: asserted combinationally from o_pkt_cnt; it stays high. Accepts continue after done and are counted.
//  Reset mid-packet: the in-flight S1/S2 contents are discarded; no stat update occurs.
//  Full throughput when not stalling: one packet per cycle.
// CONFIGURATION
//  NOC_PKT_CHECK_STALL_EN defined: 8-bit LFSR (seed = YCORD*X+XCORD+1, taps x^8+x^6+x^5+x^4+1).
//    When defined, o_ready = LFSR[1:0]!=0 registered, which gives ~75% readiness to exercise router backpressure.
//  Undefined: o_ready = 1 continuously after reset release.
// STRUCTURE
//  Package noc_pkt_pkg holds the field offsets and widths (dest x/y, src, seq, ts) and the err-code bit localparams.
//  The generator and the checker share this package.
//  Sub-module noc_seq_table: X*Y x SEQ_W register array. It has 1 read port (S1 addr) and 1 write port (S2), with internal write->read bypass.
// TESTING
//  1 Single packet dest=(XCORD,YCORD), src=3, seq=0, ts=cyc-5 -> 2 cycles later pkt_cnt=1, err_cnt=0, lat_min=lat_max=5.
//  2 10 back-to-back packets src=2 seq 0..9, valid held high -> 10 accepts in 10 cycles, err_cnt=0 (bypass exercised).
//  3 src=1 seq 0,1,3,4 -> err_cnt=1, err_code=3'b010; seq 4 not flagged (resync).
//  4 Packet dest x=XCORD+1 -> err_code[0]=1, err_cnt=1, pkt_cnt=1; seq table still advances.
//  5 ts=2^TS_W-3 with cyc=4 after wrap -> lat=7. Also src=1 seq 65535 then 0 -> no error.
//  6 Assert rst during S1 of a packet -> all outputs return to reset values, and pkt_cnt=0 after release.
//    With NOC_PKT_CHECK_STALL_EN: 200 packets all accepted; o_ready low on at least 1 cycle; o_done at packet 100.

Source files
------------

// File: rtl/noc_pkt_pkg.sv
// rtl/noc_pkt_pkg.sv - packet field layout and error-code bits shared by the NoC traffic generator and checker
package noc_pkt_pkg;

   localparam int ERR_DEST = 0;
   localparam int ERR_SEQ  = 1;
   localparam int ERR_SRC  = 2;
   localparam int ERR_W    = 3;
   localparam int CNT_W    = 32;

   typedef logic [ERR_W-1:0] err_code_t;

   // Payload sits directly above the dest x/y fields and is packed {.., ts, seq, src}.
   function automatic int src_lsb(input int x_size, input int y_size);
      return x_size + y_size;
   endfunction

   function automatic int seq_lsb(input int x_size, input int y_size, input int src_w);
      return x_size + y_size + src_w;
   endfunction

   function automatic int ts_lsb(input int x_size, input int y_size, input int src_w, input int seq_w);
      return x_size + y_size + src_w + seq_w;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/noc_pkt_checker_if.sv
// rtl/noc_pkt_checker_if.sv - valid/ready packet channel into a NoC ejection port
interface noc_pkt_checker_if #(
   parameter int TOTAL_W = 260
);
   logic [TOTAL_W-1:0] data;
   logic               valid;
   logic               ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/noc_seq_table.sv
// rtl/noc_seq_table.sv - per-source expected-sequence table, registered read with write->read bypass
module noc_seq_table #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int SEQ_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [SEQ_W-1:0]  rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [SEQ_W-1:0]  wr_data
);

   logic [SEQ_W-1:0] mem [DEPTH];

   // A read colliding with the same-cycle write returns the new value, so back-to-back packets need no bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_data <= '0;
      end else begin
         if (wr_en) mem[wr_addr] <= wr_data;
         if (rd_en) rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
      end
   end

endmodule

// File: rtl/noc_pkt_checker.sv
// rtl/noc_pkt_checker.sv - self-checking NoC ejection-port packet sink (dest/seq/src checks, latency stats)
// Optional NOC_PKT_CHECK_STALL_EN: LFSR-driven ready throttling to exercise router backpressure.
module noc_pkt_checker
   import noc_pkt_pkg::*;
#(
   parameter int XCORD      = 0,
   parameter int YCORD      = 0,
   parameter int X          = 4,
   parameter int Y          = 4,
   parameter int DATA_WIDTH = 256,
   parameter int SEQ_W      = 16,
   parameter int TS_W       = 32,
   parameter int EXP_PKTS   = 100,
   localparam int X_SIZE    = $clog2(X),
   localparam int Y_SIZE    = $clog2(Y),
   localparam int SRC_W     = $clog2(X*Y),
   localparam int TOTAL_W   = X_SIZE + Y_SIZE + DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   noc_pkt_checker_if.slave pkt,
   output logic [CNT_W-1:0] o_pkt_cnt,
   output logic [CNT_W-1:0] o_err_cnt,
   output err_code_t        o_err_code,
   output logic [TS_W-1:0]  o_lat_min,
   output logic [TS_W-1:0]  o_lat_max,
   output logic             o_done
);

   localparam int SRC_LSB = src_lsb(X_SIZE, Y_SIZE);
   localparam int SEQ_LSB = seq_lsb(X_SIZE, Y_SIZE, SRC_W);
   localparam int TS_LSB  = ts_lsb(X_SIZE, Y_SIZE, SRC_W, SEQ_W);
   localparam int NODES   = X * Y;
   localparam logic [X_SIZE-1:0] MY_X = X_SIZE'(XCORD);
   localparam logic [Y_SIZE-1:0] MY_Y = Y_SIZE'(YCORD);

   logic [TOTAL_W-1:0] data;
   logic               ready_q;
   logic               accept;
   logic [SRC_W-1:0]   in_src;
   logic               in_src_ok;
   logic [TS_W-1:0]    cyc;

   assign data      = pkt.data;
   assign pkt.ready = ready_q;
   assign accept    = pkt.valid & ready_q;
   assign in_src    = data[SRC_LSB +: SRC_W];
   assign in_src_ok = int'(in_src) < NODES;

   generate
      if (TS_LSB + TS_W < TOTAL_W) begin : g_pad
         logic unused_pad;
         assign unused_pad = ^data[TOTAL_W-1:TS_LSB+TS_W];
      end
   endgenerate

`ifdef NOC_PKT_CHECK_STALL_EN
   localparam logic [7:0] LFSR_SEED = 8'(YCORD*X + XCORD + 1);
   logic [7:0] lfsr;
   logic       run;

   // x^8+x^6+x^5+x^4+1; the first cycle after reset is always ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr    <= LFSR_SEED;
         run     <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         run     <= 1'b1;
         ready_q <= !run || (lfsr[1:0] != 2'b00);
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ready_q <= 1'b0;
      else     ready_q <= 1'b1;
   end
`endif

   logic              s1_valid;
   logic [X_SIZE-1:0] s1_dx;
   logic [Y_SIZE-1:0] s1_dy;
   logic [SRC_W-1:0]  s1_src;
   logic [SEQ_W-1:0]  s1_seq;
   logic [SEQ_W-1:0]  s1_exp;
   logic [TS_W-1:0]   s1_lat;
   logic              s1_src_ok;
   err_code_t         err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc      <= '0;
         s1_valid <= 1'b0;
         s1_dx    <= '0;
         s1_dy    <= '0;
         s1_src   <= '0;
         s1_seq   <= '0;
         s1_lat   <= '0;
      end else begin
         cyc      <= cyc + 1'b1;
         s1_valid <= accept;
         if (accept) begin
            s1_dx  <= data[0 +: X_SIZE];
            s1_dy  <= data[X_SIZE +: Y_SIZE];
            s1_src <= in_src;
            s1_seq <= data[SEQ_LSB +: SEQ_W];
            s1_lat <= cyc - data[TS_LSB +: TS_W];
         end
      end
   end

   noc_seq_table #(
      .DEPTH  (NODES),
      .ADDR_W (SRC_W),
      .SEQ_W  (SEQ_W)
   ) u_seq_table (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (accept & in_src_ok),
      .rd_addr (in_src),
      .rd_data (s1_exp),
      .wr_en   (s1_valid & s1_src_ok),
      .wr_addr (s1_src),
      .wr_data (s1_seq + 1'b1)
   );

   always_comb begin
      s1_src_ok     = int'(s1_src) < NODES;
      err           = '0;
      err[ERR_DEST] = (s1_dx != MY_X) || (s1_dy != MY_Y);
      err[ERR_SRC]  = !s1_src_ok;
      err[ERR_SEQ]  = s1_src_ok && (s1_seq != s1_exp);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_pkt_cnt  <= '0;
         o_err_cnt  <= '0;
         o_err_code <= '0;
         o_lat_min  <= '1;
         o_lat_max  <= '0;
      end else if (s1_valid) begin
         o_pkt_cnt  <= sat_inc(o_pkt_cnt);
         if (|err) o_err_cnt <= sat_inc(o_err_cnt);
         o_err_code <= o_err_code | err;
         if (s1_src_ok) begin
            if (s1_lat < o_lat_min) o_lat_min <= s1_lat;
            if (s1_lat > o_lat_max) o_lat_max <= s1_lat;
         end
      end
   end

   assign o_done = o_pkt_cnt >= CNT_W'(EXP_PKTS);

endmodule

// File: tb/tb_noc_pkt_checker.sv
// tb/tb_noc_pkt_checker.sv - randomized self-checking bench for noc_pkt_checker against a packet-level model
module tb_noc_pkt_checker;

   localparam int XC = 1;
   localparam int YC = 2;
   localparam int X = 3;
   localparam int Y = 3;
   localparam int DW = 64;
   localparam int SEQ_W = 16;
   localparam int TS_W = 10;
   localparam int EXP = 100;
   localparam int TW = 4 + DW;
   localparam int NODES = X * Y;
   localparam int unsigned TS_MASK = (1 << TS_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] o_pkt_cnt, o_err_cnt;
   logic [2:0] o_err_code;
   logic [TS_W-1:0] o_lat_min, o_lat_max;
   logic o_done;

   int checks = 0;
   int errors = 0;
   int unsigned cyc_m;
   int unsigned exp_seq [16];
   int unsigned pkt_m, err_m, lat_min_m, lat_max_m;
   logic [2:0] code_m;
   bit stalled;

   always #5 clk = ~clk;

   noc_pkt_checker_if #(.TOTAL_W(TW)) pkt ();

   noc_pkt_checker #(
      .XCORD(XC), .YCORD(YC), .X(X), .Y(Y), .DATA_WIDTH(DW),
      .SEQ_W(SEQ_W), .TS_W(TS_W), .EXP_PKTS(EXP)
   ) dut (
      .clk(clk), .rst(rst), .pkt(pkt),
      .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt), .o_err_code(o_err_code),
      .o_lat_min(o_lat_min), .o_lat_max(o_lat_max), .o_done(o_done)
   );

   always @(posedge clk or posedge rst)
      if (rst) cyc_m <= 0;
      else     cyc_m <= cyc_m + 1;

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) exp_seq[i] = 0;
      pkt_m = 0; err_m = 0; code_m = 3'b000;
      lat_min_m = TS_MASK; lat_max_m = 0;
   endfunction

   function automatic void model_accept(input int dx, input int dy, input int src, input int seq,
                                        input int ts, input int unsigned acc_cyc);
      bit e_dest = (dx != XC) || (dy != YC);
      bit e_src = (src >= NODES);
      bit e_seq = 1'b0;
      int unsigned lat;
      if (!e_src) begin
         e_seq = (seq != exp_seq[src]);
         exp_seq[src] = (seq + 1) % (1 << SEQ_W);
         lat = (acc_cyc - ts) & TS_MASK;
         if (lat < lat_min_m) lat_min_m = lat;
         if (lat > lat_max_m) lat_max_m = lat;
      end
      if (pkt_m != 32'hFFFF_FFFF) pkt_m++;
      if ((e_dest || e_seq || e_src) && err_m != 32'hFFFF_FFFF) err_m++;
      code_m = code_m | {e_src, e_seq, e_dest};
   endfunction

   task automatic apply_reset();
      pkt.valid = 1'b0;
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input int dx, input int dy, input int src, input int seq, input int ts);
      int n = 0;
      pkt.data = TW'({$urandom, $urandom, $urandom});
      pkt.data[33:0] = {TS_W'(ts), SEQ_W'(seq), 4'(src), 2'(dy), 2'(dx)};
      pkt.valid = 1'b1;
      while (!pkt.ready && n < 64) begin @(posedge clk); #1; n++; end
      if (n > 0) stalled = 1'b1;
      checks++;
      if (pkt.ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout: ready=%b required 1", pkt.ready);
      end else begin
         model_accept(dx, dy, src, seq, ts, cyc_m);
         @(posedge clk); #1;
      end
      pkt.valid = 1'b0;
   endtask

   task automatic test_reset();
      pkt.valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({pkt.ready, o_pkt_cnt, o_err_cnt, o_err_code, o_lat_min, o_lat_max, o_done} !==
          {1'b0, 32'd0, 32'd0, 3'd0, {TS_W{1'b1}}, {TS_W{1'b0}}, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: ready=%b pkt=%0d err=%0d code=%b min=%0d max=%0d done=%b required 0 0 0 000 %0d 0 0",
                  pkt.ready, o_pkt_cnt, o_err_cnt, o_err_code, o_lat_min, o_lat_max, o_done, TS_MASK);
      end
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (pkt.ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: ready=%b required 0", pkt.ready); end
      @(posedge clk); #1;
      checks++;
      if (pkt.ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: ready=%b required 1", pkt.ready); end
   endtask

   task automatic test_single();
      apply_reset();
      send(XC, YC, 3, 0, int'((cyc_m - 5) & TS_MASK));
      checks++;
      if (o_pkt_cnt !== 32'd0) begin errors++; $display("FAIL single_early: pkt_cnt=%0d required 0", o_pkt_cnt); end
      @(posedge clk); #1;
      checks++;
      if ({o_pkt_cnt, o_err_cnt, o_lat_min, o_lat_max} !== {32'd1, 32'd0, TS_W'(5), TS_W'(5)}) begin
         errors++;
         $display("FAIL single_stats: pkt=%0d err=%0d min=%0d max=%0d required 1 0 5 5",
                  o_pkt_cnt, o_err_cnt, o_lat_min, o_lat_max);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned start;
      apply_reset();
      start = cyc_m;
      for (int i = 0; i < 10; i++) send(XC, YC, 2, i, int'(cyc_m & TS_MASK));
`ifndef NOC_PKT_CHECK_STALL_EN
      checks++;
      if (cyc_m - start != 10) begin errors++; $display("FAIL b2b_cycles: cycles=%0d required 10", cyc_m - start); end
`endif
      idle(2);
      checks++;
      if ({o_pkt_cnt, o_err_cnt, o_err_code} !== {32'd10, 32'd0, 3'b000}) begin
         errors++;
         $display("FAIL b2b_stats: pkt=%0d err=%0d code=%b required 10 0 000", o_pkt_cnt, o_err_cnt, o_err_code);
      end
   endtask

   task automatic test_seq_gap();
      int seqs [4] = '{0, 1, 3, 4};
      apply_reset();
      foreach (seqs[i]) send(XC, YC, 1, seqs[i], int'(cyc_m & TS_MASK));
      idle(2);
      checks++;
      if ({o_pkt_cnt, o_err_cnt, o_err_code} !== {32'd4, 32'd1, 3'b010}) begin
         errors++;
         $display("FAIL seq_gap: pkt=%0d err=%0d code=%b required 4 1 010", o_pkt_cnt, o_err_cnt, o_err_code);
      end
   endtask

   task automatic test_dest();
      apply_reset();
      send(XC + 1, YC, 5, 0, int'(cyc_m & TS_MASK));
      idle(2);
      checks++;
      if ({o_pkt_cnt, o_err_cnt, o_err_code} !== {32'd1, 32'd1, 3'b001}) begin
         errors++;
         $display("FAIL dest_err: pkt=%0d err=%0d code=%b required 1 1 001", o_pkt_cnt, o_err_cnt, o_err_code);
      end
      send(XC, YC, 5, 1, int'(cyc_m & TS_MASK));
      idle(2);
      checks++;
      if ({o_pkt_cnt, o_err_cnt} !== {32'd2, 32'd1}) begin
         errors++;
         $display("FAIL dest_table_advance: pkt=%0d err=%0d required 2 1", o_pkt_cnt, o_err_cnt);
      end
   endtask

   task automatic test_wrap();
      int n = 0;
      int unsigned exp_lat;
      apply_reset();
      while ((cyc_m & TS_MASK) != 4 && n < 2100) begin @(posedge clk); #1; n++; end
      checks++;
      if ((cyc_m & TS_MASK) != 4) begin errors++; $display("FAIL wrap_wait: cyc=%0d required 4", cyc_m & TS_MASK); end
      send(XC, YC, 6, 0, int'(TS_MASK - 2));
      idle(2);
`ifdef NOC_PKT_CHECK_STALL_EN
      exp_lat = lat_max_m;
`else
      exp_lat = 7;
`endif
      checks++;
      if ({o_lat_min, o_lat_max} !== {TS_W'(exp_lat), TS_W'(exp_lat)}) begin
         errors++;
         $display("FAIL lat_wrap: min=%0d max=%0d required %0d", o_lat_min, o_lat_max, exp_lat);
      end
      send(XC, YC, 1, 65534, int'(cyc_m & TS_MASK));
      send(XC, YC, 1, 65535, int'(cyc_m & TS_MASK));
      send(XC, YC, 1, 0, int'(cyc_m & TS_MASK));
      idle(2);
      checks++;
      if ({o_pkt_cnt, o_err_cnt, o_err_code} !== {32'd4, 32'd1, 3'b010}) begin
         errors++;
         $display("FAIL seq_wrap: pkt=%0d err=%0d code=%b required 4 1 010", o_pkt_cnt, o_err_cnt, o_err_code);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      send(XC + 1, YC, 12, 7, int'(cyc_m & TS_MASK));
      rst = 1'b1;
      #1;
      checks++;
      if ({pkt.ready, o_pkt_cnt, o_err_cnt, o_err_code, o_lat_min, o_done} !==
          {1'b0, 32'd0, 32'd0, 3'd0, {TS_W{1'b1}}, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_values: ready=%b pkt=%0d err=%0d code=%b min=%0d done=%b",
                  pkt.ready, o_pkt_cnt, o_err_cnt, o_err_code, o_lat_min, o_done);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      idle(3);
      checks++;
      if ({o_pkt_cnt, o_err_cnt, o_err_code} !== {32'd0, 32'd0, 3'd0}) begin
         errors++;
         $display("FAIL reset_mid_release: pkt=%0d err=%0d code=%b required 0 0 000", o_pkt_cnt, o_err_cnt, o_err_code);
      end
   endtask

   task automatic test_random();
      int dx, dy, src, seq;
      apply_reset();
      for (int i = 0; i < 300; i++) begin
         dx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : XC;
         dy = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : YC;
         src = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NODES, 15)) : int'($urandom_range(0, NODES - 1));
         seq = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'(exp_seq[src]);
         send(dx, dy, src, seq, int'((cyc_m - $urandom_range(0, 200)) & TS_MASK));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(2);
      checks++;
      if ({o_pkt_cnt, o_err_cnt, o_err_code} !== {pkt_m, err_m, code_m}) begin
         errors++;
         $display("FAIL random_counts: pkt=%0d err=%0d code=%b required %0d %0d %b",
                  o_pkt_cnt, o_err_cnt, o_err_code, pkt_m, err_m, code_m);
      end
      checks++;
      if ({o_lat_min, o_lat_max} !== {TS_W'(lat_min_m), TS_W'(lat_max_m)}) begin
         errors++;
         $display("FAIL random_latency: min=%0d max=%0d required %0d %0d", o_lat_min, o_lat_max, lat_min_m, lat_max_m);
      end
   endtask

   task automatic test_done();
      int src;
      apply_reset();
      stalled = 1'b0;
      for (int i = 0; i < 99; i++) begin
         src = i % NODES;
         send(XC, YC, src, int'(exp_seq[src]), int'(cyc_m & TS_MASK));
      end
      idle(2);
      checks++;
      if ({o_done, o_pkt_cnt} !== {1'b0, 32'd99}) begin
         errors++;
         $display("FAIL done_early: done=%b pkt=%0d required 0 99", o_done, o_pkt_cnt);
      end
      send(XC, YC, 0, int'(exp_seq[0]), int'(cyc_m & TS_MASK));
      idle(2);
      checks++;
      if ({o_done, o_pkt_cnt} !== {1'b1, 32'd100}) begin
         errors++;
         $display("FAIL done_at_exp: done=%b pkt=%0d required 1 100", o_done, o_pkt_cnt);
      end
      for (int i = 0; i < 100; i++) begin
         src = i % NODES;
         send(XC, YC, src, int'(exp_seq[src]), int'(cyc_m & TS_MASK));
      end
      idle(2);
      checks++;
      if ({o_done, o_pkt_cnt, o_err_cnt} !== {1'b1, 32'd200, 32'd0}) begin
         errors++;
         $display("FAIL done_after: done=%b pkt=%0d err=%0d required 1 200 0", o_done, o_pkt_cnt, o_err_cnt);
      end
`ifdef NOC_PKT_CHECK_STALL_EN
      checks++;
      if (stalled !== 1'b1) begin errors++; $display("FAIL stall_seen: stalled=%b required 1", stalled); end
`endif
   endtask

   initial begin
      pkt.valid = 1'b0;
      pkt.data = '0;
      stalled = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_back_to_back();
      test_seq_gap();
      test_dest();
      test_wrap();
      test_reset_mid();
      test_random();
      test_done();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
